multi_signal_expansioner: RTL and testbench
===========================================

Name: multi_signal_expansioner

Overview:
- Multi-channel, parametrised successor to the single-channel signal expansioner.
- Each channel detects a rising edge on its input and emits a fixed-width output pulse of per-channel programmable length.
- Each channel has a selectable retrigger mode and reports triggers it drops.
- Sits between discriminator/trigger inputs and the downstream coincidence/readout logic.

Parameters:
- CH_NUM, 4, number of independent channels.
- MAX_EXTEND_LEN_WIDTH, 5, width of each channel's pulse-length field; maximum length is 2^W-1 cycles.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  global trigger enable; 0 blocks new triggers, and pulses in flight complete.
- EXTEND_LEN  input  CH_NUM*MAX_EXTEND_LEN_WIDTH  per-channel pulse length in cycles; channel c uses bits [c*W +: W].
- RETRIG  input  CH_NUM  per-channel mode: 1 = retriggerable, 0 = non-retriggerable.
- SIG_IN  input  CH_NUM  raw channel inputs, synchronous to CLK.
- SIG_OUT  output  CH_NUM  stretched pulses, registered.
- TRIG_DROP  output  CH_NUM  one-cycle flag: an edge was ignored in non-retrigger mode.

Behaviour:
- Reset: SIG_OUT=0, TRIG_DROP=0, all counters=0, input history register=0. A reset asserted mid-pulse ends the pulse on the next edge; no residual output.
- Edge detect: sig_d[c] holds SIG_IN[c] from the previous cycle. edge[c] = SIG_IN[c] & ~sig_d[c] & ENABLE.
- Level-high inputs never produce a second trigger. Only 0->1 transitions count.
- Per-channel state:
  - IDLE (SIG_OUT=0).
  - ACTIVE (SIG_OUT=1, down-counter cnt).
- Effective length: len_eff = EXTEND_LEN, except 0 maps to 1.
- EXTEND_LEN is sampled only at trigger time. Changes mid-pulse do not alter the pulse in flight.
- IDLE -> ACTIVE: on the clock edge that samples edge[c]=1. SIG_OUT rises in that same cycle; cnt is loaded with len_eff-1.
- Latency: 1 cycle from SIG_IN rise to SIG_OUT rise.
- ACTIVE, cnt>0, no accepted edge: cnt decrements.
- ACTIVE, cnt==0, no accepted edge: ACTIVE -> IDLE. The pulse width is exactly len_eff cycles.
- Edge while ACTIVE and cnt>0:
  - RETRIG=1: cnt reloads with len_eff-1 from the current EXTEND_LEN; output stays high continuously.
  - RETRIG=0: edge is ignored, cnt continues, and TRIG_DROP[c]=1 for exactly one cycle.
- Edge while ACTIVE and cnt==0 (final cycle): accepted as a new trigger in both modes. cnt reloads, output stays high with no gap, and TRIG_DROP stays 0.
- Channels are fully independent. No cross-channel interaction.
- Counters are MAX_EXTEND_LEN_WIDTH bits wide; no wrap is possible because the load value is at most 2^W-2.

Optional Feature:
- Macro: SIG_EXP_OR_OUT_EN.
- Defined: adds output SIG_OR (1 bit, registered), equal to the OR of SIG_OUT, with the same cycle alignment as SIG_OUT; reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sig_exp_pkg holds:
  - default CH_NUM and MAX_EXTEND_LEN_WIDTH constants;
  - state encoding (IDLE/ACTIVE);
  - a localparam function mapping len 0->1.
- Sub-module sig_exp_channel implements one channel: edge detect, counter, state, and drop flag. The top level instantiates it CH_NUM times via generate and slices EXTEND_LEN.

Test Plan:
1. Reset, ENABLE=1, ch0 EXTEND_LEN=4, RETRIG=0; SIG_IN[0] high for 20 cycles -> SIG_OUT[0] high exactly 4 cycles starting 1 cycle after the rise, then low despite the held input. TRIG_DROP stays 0.
2. ch1 EXTEND_LEN=8, RETRIG=1; rising edges at t=0 and t=5 (1-cycle pulses) -> SIG_OUT[1] high continuously for 13 cycles.
3. Same as scenario 2 with RETRIG=0 -> SIG_OUT[1] high 8 cycles. TRIG_DROP[1] pulses once, at the cycle sampling the t=5 edge.
4. ch2 EXTEND_LEN=3, edge exactly on the final ACTIVE cycle, RETRIG=0 -> SIG_OUT[2] high 6 cycles with no gap, no drop flag. Also EXTEND_LEN=0 -> 1-cycle pulse.
5. Mid-pulse: change EXTEND_LEN 4->31 -> width stays 4. Assert RESET for 1 cycle at pulse cycle 2 -> SIG_OUT=0 the next cycle, and a new edge after reset triggers normally.
6. ENABLE=0 with edges on all channels -> no outputs. All 4 channels triggered in the same cycle with lengths 1/2/3/4 -> independent pulses of those widths. With SIG_EXP_OR_OUT_EN defined, SIG_OR is high 4 cycles.

Source files
------------

// File: rtl/sig_exp_pkg.sv
// Shared constants for the multi-channel signal expansioner: default sizes,
// channel state encoding and the pulse-length mapping helper.
package sig_exp_pkg;

    localparam int CH_NUM_DEF = 4;
    localparam int LEN_W_DEF  = 5;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    // A programmed length of zero still produces a single-cycle pulse.
    function automatic logic [31:0] len_eff_f(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/sig_exp_channel.sv
// One expansioner channel: rising-edge detect, pulse down-counter and drop flag.
// SIG_EXP_OR_OUT_EN exposes the next-state output so the top can register an OR.
module sig_exp_channel
    import sig_exp_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             retrig_i,
    input  logic             sig_i,
    output logic             sig_out_o,
    output logic             drop_o
`ifdef SIG_EXP_OR_OUT_EN
    ,
    output logic             sig_out_d_o
`endif
);

    logic             sig_d_q;
    logic             state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             edge_det;
    logic [LEN_W-1:0] load_val;

    assign edge_det = sig_i & ~sig_d_q & enable_i;
    assign load_val = LEN_W'(len_eff_f(32'(len_i)) - 32'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_det) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = load_val;
                end
            end
            default: begin
                // An edge on the final cycle extends the pulse in either mode.
                if (edge_det && (retrig_i || cnt_q == '0)) begin
                    cnt_d = load_val;
                end else begin
                    drop_d = edge_det;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_d_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            sig_d_q <= sig_i;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign sig_out_o = state_q;
    assign drop_o    = drop_q;
`ifdef SIG_EXP_OR_OUT_EN
    assign sig_out_d_o = state_d;
`endif

endmodule

// File: rtl/multi_signal_expansioner.sv
// CH_NUM independent pulse stretchers with per-channel length and retrigger mode.
// SIG_EXP_OR_OUT_EN adds a registered SIG_OR output aligned with SIG_OUT.
module multi_signal_expansioner
    import sig_exp_pkg::*;
#(
    parameter int CH_NUM               = CH_NUM_DEF,
    parameter int MAX_EXTEND_LEN_WIDTH = LEN_W_DEF
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   ENABLE,
    input  logic [CH_NUM*MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN,
    input  logic [CH_NUM-1:0]                      RETRIG,
    input  logic [CH_NUM-1:0]                      SIG_IN,
    output logic [CH_NUM-1:0]                      SIG_OUT,
    output logic [CH_NUM-1:0]                      TRIG_DROP
`ifdef SIG_EXP_OR_OUT_EN
    ,
    output logic                                   SIG_OR
`endif
);

`ifdef SIG_EXP_OR_OUT_EN
    logic [CH_NUM-1:0] sig_out_d;
    logic              sig_or_q;
`endif

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        sig_exp_channel #(
            .LEN_W(MAX_EXTEND_LEN_WIDTH)
        ) u_ch (
            .clk_i    (CLK),
            .rst_i    (RESET),
            .enable_i (ENABLE),
            .len_i    (EXTEND_LEN[c*MAX_EXTEND_LEN_WIDTH +: MAX_EXTEND_LEN_WIDTH]),
            .retrig_i (RETRIG[c]),
            .sig_i    (SIG_IN[c]),
            .sig_out_o(SIG_OUT[c]),
            .drop_o   (TRIG_DROP[c])
`ifdef SIG_EXP_OR_OUT_EN
            ,
            .sig_out_d_o(sig_out_d[c])
`endif
        );
    end

`ifdef SIG_EXP_OR_OUT_EN
    // Registering the OR of next states keeps SIG_OR glitch-free and aligned.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sig_or_q <= 1'b0;
        end else begin
            sig_or_q <= |sig_out_d;
        end
    end

    assign SIG_OR = sig_or_q;
`endif

endmodule

// File: tb/tb_multi_signal_expansioner.sv
// Scoreboard bench for multi_signal_expansioner; checks SIG_OR when SIG_EXP_OR_OUT_EN is defined.
module tb_multi_signal_expansioner;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b1;
    logic [19:0] EXTEND_LEN = '0;
    logic [3:0]  RETRIG = '0;
    logic [3:0]  SIG_IN = '0;
    logic [3:0]  SIG_OUT;
    logic [3:0]  TRIG_DROP;
`ifdef SIG_EXP_OR_OUT_EN
    logic        SIG_OR;
`endif

    multi_signal_expansioner #(
        .CH_NUM(4),
        .MAX_EXTEND_LEN_WIDTH(5)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .EXTEND_LEN(EXTEND_LEN),
        .RETRIG    (RETRIG),
        .SIG_IN    (SIG_IN),
        .SIG_OUT   (SIG_OUT),
        .TRIG_DROP (TRIG_DROP)
`ifdef SIG_EXP_OR_OUT_EN
        ,
        .SIG_OR    (SIG_OR)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  sig;
        logic [19:0] len;
        logic        rst;
        logic        en;
    } stim_t;

    typedef struct {
        logic [3:0] out;
        logic [3:0] drop;
    } exp_t;

    stim_t       stim_q[$];
    exp_t        exp_q[$];
    logic [19:0] cur_len = '0;
    logic        cur_rst = 1'b0;
    logic        cur_en  = 1'b1;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic set_len(input int c, input int v);
        cur_len[c*5 +: 5] = 5'(v);
    endtask

    // Queue one cycle of stimulus together with the outputs expected after it is sampled.
    task automatic push(input logic [3:0] s, input logic [3:0] o, input logic [3:0] d);
        stim_t st;
        exp_t  ex;
        st.sig = s;
        st.len = cur_len;
        st.rst = cur_rst;
        st.en  = cur_en;
        ex.out  = o;
        ex.drop = d;
        stim_q.push_back(st);
        exp_q.push_back(ex);
    endtask

    task automatic apply(input stim_t st);
        SIG_IN     = st.sig;
        EXTEND_LEN = st.len;
        RESET      = st.rst;
        ENABLE     = st.en;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        int   cyc = 0;
        set_len(0, 4); set_len(1, 4); set_len(2, 4); set_len(3, 4);
        cur_rst = 1'b1;
        for (int i = 0; i < 3; i++) push(4'hF, 4'h0, 4'h0);
        cur_rst = 1'b0;
        for (int i = 0; i < 2; i++) push(4'h0, 4'h0, 4'h0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            n_cmp += 2;
            if (SIG_OUT !== e.out) begin
                n_err++; $display("FAIL reset_out cyc=%0d got=%b want=%b", cyc, SIG_OUT, e.out);
            end
            if (TRIG_DROP !== e.drop) begin
                n_err++; $display("FAIL reset_drop cyc=%0d got=%b want=%b", cyc, TRIG_DROP, e.drop);
            end
            cyc++;
        end
    endtask

    task automatic test_level_hold();
        exp_t e;
        int   cyc = 0;
        RETRIG = 4'b0000;
        set_len(0, 4);
        for (int t = 0; t < 26; t++)
            push((t < 20) ? 4'h1 : 4'h0, (t < 4) ? 4'h1 : 4'h0, 4'h0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            n_cmp += 2;
            if (SIG_OUT !== e.out) begin
                n_err++; $display("FAIL hold_out cyc=%0d got=%b want=%b", cyc, SIG_OUT, e.out);
            end
            if (TRIG_DROP !== e.drop) begin
                n_err++; $display("FAIL hold_drop cyc=%0d got=%b want=%b", cyc, TRIG_DROP, e.drop);
            end
            cyc++;
        end
    endtask

    task automatic test_retrig();
        exp_t e;
        int   cyc = 0;
        RETRIG = 4'b0010;
        set_len(1, 8);
        for (int t = 0; t < 16; t++)
            push((t == 0 || t == 5) ? 4'h2 : 4'h0, (t <= 12) ? 4'h2 : 4'h0, 4'h0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            n_cmp += 2;
            if (SIG_OUT !== e.out) begin
                n_err++; $display("FAIL retrig_out cyc=%0d got=%b want=%b", cyc, SIG_OUT, e.out);
            end
            if (TRIG_DROP !== e.drop) begin
                n_err++; $display("FAIL retrig_drop cyc=%0d got=%b want=%b", cyc, TRIG_DROP, e.drop);
            end
            cyc++;
        end
    endtask

    task automatic test_no_retrig();
        exp_t e;
        int   cyc = 0;
        RETRIG = 4'b0000;
        set_len(1, 8);
        for (int t = 0; t < 12; t++)
            push((t == 0 || t == 5) ? 4'h2 : 4'h0, (t <= 7) ? 4'h2 : 4'h0, (t == 5) ? 4'h2 : 4'h0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            n_cmp += 2;
            if (SIG_OUT !== e.out) begin
                n_err++; $display("FAIL noretrig_out cyc=%0d got=%b want=%b", cyc, SIG_OUT, e.out);
            end
            if (TRIG_DROP !== e.drop) begin
                n_err++; $display("FAIL noretrig_drop cyc=%0d got=%b want=%b", cyc, TRIG_DROP, e.drop);
            end
            cyc++;
        end
    endtask

    task automatic test_final_cycle();
        exp_t e;
        int   cyc = 0;
        RETRIG = 4'b0000;
        set_len(2, 3);
        for (int t = 0; t < 10; t++)
            push((t == 0 || t == 3) ? 4'h4 : 4'h0, (t <= 5) ? 4'h4 : 4'h0, 4'h0);
        set_len(2, 0);
        push(4'h4, 4'h4, 4'h0);
        for (int t = 0; t < 3; t++) push(4'h0, 4'h0, 4'h0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            n_cmp += 2;
            if (SIG_OUT !== e.out) begin
                n_err++; $display("FAIL final_out cyc=%0d got=%b want=%b", cyc, SIG_OUT, e.out);
            end
            if (TRIG_DROP !== e.drop) begin
                n_err++; $display("FAIL final_drop cyc=%0d got=%b want=%b", cyc, TRIG_DROP, e.drop);
            end
            cyc++;
        end
    endtask

    task automatic test_midpulse();
        exp_t e;
        int   cyc = 0;
        RETRIG = 4'b0000;
        set_len(0, 4);
        push(4'h1, 4'h1, 4'h0);
        set_len(0, 31);
        for (int t = 0; t < 3; t++) push(4'h0, 4'h1, 4'h0);
        for (int t = 0; t < 3; t++) push(4'h0, 4'h0, 4'h0);
        set_len(0, 4);
        push(4'h1, 4'h1, 4'h0);
        push(4'h0, 4'h1, 4'h0);
        cur_rst = 1'b1;
        push(4'h0, 4'h0, 4'h0);
        cur_rst = 1'b0;
        push(4'h0, 4'h0, 4'h0);
        push(4'h1, 4'h1, 4'h0);
        for (int t = 0; t < 3; t++) push(4'h0, 4'h1, 4'h0);
        for (int t = 0; t < 2; t++) push(4'h0, 4'h0, 4'h0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            n_cmp += 2;
            if (SIG_OUT !== e.out) begin
                n_err++; $display("FAIL midpulse_out cyc=%0d got=%b want=%b", cyc, SIG_OUT, e.out);
            end
            if (TRIG_DROP !== e.drop) begin
                n_err++; $display("FAIL midpulse_drop cyc=%0d got=%b want=%b", cyc, TRIG_DROP, e.drop);
            end
            cyc++;
        end
    endtask

    task automatic test_enable_all();
        exp_t e;
        int   cyc = 0;
        RETRIG = 4'b0000;
        set_len(0, 1); set_len(1, 2); set_len(2, 3); set_len(3, 4);
        cur_en = 1'b0;
        push(4'hF, 4'h0, 4'h0);
        push(4'h0, 4'h0, 4'h0);
        push(4'hF, 4'h0, 4'h0);
        push(4'h0, 4'h0, 4'h0);
        cur_en = 1'b1;
        push(4'hF, 4'hF, 4'h0);
        push(4'h0, 4'hE, 4'h0);
        push(4'h0, 4'hC, 4'h0);
        push(4'h0, 4'h8, 4'h0);
        push(4'h0, 4'h0, 4'h0);
        push(4'h0, 4'h0, 4'h0);
        // a pulse in flight finishes after ENABLE drops; blocked edges are not drops
        push(4'h8, 4'h8, 4'h0);
        cur_en = 1'b0;
        push(4'h0, 4'h8, 4'h0);
        push(4'h8, 4'h8, 4'h0);
        push(4'h0, 4'h8, 4'h0);
        push(4'h0, 4'h0, 4'h0);
        cur_en = 1'b1;
        push(4'h0, 4'h0, 4'h0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front();
            n_cmp += 2;
            if (SIG_OUT !== e.out) begin
                n_err++; $display("FAIL enable_out cyc=%0d got=%b want=%b", cyc, SIG_OUT, e.out);
            end
            if (TRIG_DROP !== e.drop) begin
                n_err++; $display("FAIL enable_drop cyc=%0d got=%b want=%b", cyc, TRIG_DROP, e.drop);
            end
`ifdef SIG_EXP_OR_OUT_EN
            n_cmp++;
            if (SIG_OR !== (e.out != 4'h0)) begin
                n_err++; $display("FAIL enable_or cyc=%0d got=%b want=%b", cyc, SIG_OR, (e.out != 4'h0));
            end
`endif
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_level_hold();
        test_retrig();
        test_no_retrig();
        test_final_cycle();
        test_midpulse();
        test_enable_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
